// File: rtl/if_stage.sv
`timescale 1ns/1ps
// Instruction fetch stage with IF/ID register, one-entry skid buffer
// and single-outstanding instruction memory port.
module if_stage #(
    parameter int                       WORD_BITWIDTH = 32,
    parameter logic [WORD_BITWIDTH-1:0] RESET_PC      = '0,
    parameter logic [WORD_BITWIDTH-1:0] NOP_INST      = 'h13
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req,
    output logic [WORD_BITWIDTH-1:0] imem_addr,
    input  logic                     imem_rvalid,
    input  logic [WORD_BITWIDTH-1:0] imem_rdata,
    input  logic                     stall,
    input  logic                     redirect_valid,
    input  logic [WORD_BITWIDTH-1:0] redirect_pc,
    output logic                     if_id_valid,
    output logic [WORD_BITWIDTH-1:0] if_id_pc,
    output logic [WORD_BITWIDTH-1:0] if_id_instruction
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [WORD_BITWIDTH-1:0] pc_q, pc_d;
    logic [WORD_BITWIDTH-1:0] pc_tgt_q, pc_tgt_d;
    logic                     discard_q, discard_d;
    logic [WORD_BITWIDTH-1:0] skid_pc_q, skid_pc_d;
    logic [WORD_BITWIDTH-1:0] skid_inst_q, skid_inst_d;
    logic                     vld_q, vld_d;
    logic [WORD_BITWIDTH-1:0] id_pc_q, id_pc_d;
    logic [WORD_BITWIDTH-1:0] id_inst_q, id_inst_d;
    logic                     accept;
    logic [WORD_BITWIDTH-1:0] pc_inc;

    assign accept = !stall || !vld_q;
    assign pc_inc = pc_q + WORD_BITWIDTH'(4);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pc_tgt_d    = pc_tgt_q;
        discard_d   = discard_q;
        skid_pc_d   = skid_pc_q;
        skid_inst_d = skid_inst_q;
        vld_d       = vld_q;
        id_pc_d     = id_pc_q;
        id_inst_d   = id_inst_q;
        if (redirect_valid) begin
            vld_d     = 1'b0;
            id_inst_d = NOP_INST;
            unique case (state_q)
                S_WAIT: begin
                    if (imem_rvalid) begin
                        pc_d      = redirect_pc;
                        discard_d = 1'b0;
                    end else begin
                        // response still owed; park the target until it lands
                        discard_d = 1'b1;
                        pc_tgt_d  = redirect_pc;
                    end
                end
                default: begin
                    pc_d    = redirect_pc;
                    state_d = S_IDLE;
                end
            endcase
        end else begin
            if (!stall) begin
                vld_d     = 1'b0;
                id_inst_d = NOP_INST;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (!stall) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (discard_q) begin
                            pc_d      = pc_tgt_q;
                            discard_d = 1'b0;
                        end else if (accept) begin
                            vld_d     = 1'b1;
                            id_pc_d   = pc_q;
                            id_inst_d = imem_rdata;
                            pc_d      = pc_inc;
                            state_d   = stall ? S_IDLE : S_WAIT;
                        end else begin
                            skid_pc_d   = pc_q;
                            skid_inst_d = imem_rdata;
                            pc_d        = pc_inc;
                            state_d     = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (accept) begin
                        vld_d     = 1'b1;
                        id_pc_d   = skid_pc_q;
                        id_inst_d = skid_inst_q;
                        state_d   = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            pc_tgt_q    <= '0;
            discard_q   <= 1'b0;
            skid_pc_q   <= '0;
            skid_inst_q <= '0;
            vld_q       <= 1'b0;
            id_pc_q     <= '0;
            id_inst_q   <= NOP_INST;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pc_tgt_q    <= pc_tgt_d;
            discard_q   <= discard_d;
            skid_pc_q   <= skid_pc_d;
            skid_inst_q <= skid_inst_d;
            vld_q       <= vld_d;
            id_pc_q     <= id_pc_d;
            id_inst_q   <= id_inst_d;
        end
    end

    assign imem_req          = (state_q == S_WAIT);
    assign imem_addr         = pc_q;
    assign if_id_valid       = vld_q;
    assign if_id_pc          = id_pc_q;
    assign if_id_instruction = id_inst_q;

endmodule

// File: tb/tb_if_stage.sv
`timescale 1ns/1ps
// Randomized scoreboard bench for if_stage: program-order stream model
// with redirects, a variable-latency memory and a wrap-around instance.
module tb_if_stage;

    localparam logic [31:0] NOP  = 32'h00000013;
    localparam logic [31:0] KEY  = 32'hA5A50000;
    localparam logic [31:0] RPC2 = 32'hFFFFFFFC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        imem_req, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        stall, redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_id_valid;
    logic [31:0] if_id_pc, if_id_instruction;

    logic        req2, rvalid2, valid2;
    logic [31:0] addr2, rdata2, pc2, inst2;
    logic        stall2 = 1'b0;
    logic        redir2 = 1'b0;
    logic [31:0] rpc2 = 32'h0;

    if_stage dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .stall(stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .if_id_valid(if_id_valid), .if_id_pc(if_id_pc),
        .if_id_instruction(if_id_instruction)
    );

    if_stage #(.RESET_PC(RPC2)) dut2 (
        .clk(clk), .rst(rst),
        .imem_req(req2), .imem_addr(addr2),
        .imem_rvalid(rvalid2), .imem_rdata(rdata2),
        .stall(stall2), .redirect_valid(redir2),
        .redirect_pc(rpc2),
        .if_id_valid(valid2), .if_id_pc(pc2),
        .if_id_instruction(inst2)
    );

    assign rvalid2 = req2;
    assign rdata2  = addr2 ^ KEY;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // reference model: expected program-order stream seen by ID
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;
    exp_t        exp_q[$];
    logic [31:0] next_pc;
    logic [31:0] exp2;
    int          cons = 0;
    int          idle = 0;
    logic        prev_redir = 1'b0;

    function automatic void refill();
        while (exp_q.size() < 4) begin
            exp_q.push_back({next_pc, next_pc ^ KEY});
            next_pc = next_pc + 32'd4;
        end
    endfunction

    // memory model state
    int          lat = 0;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = '0;
    logic        hold_chk = 1'b0;
    bit          fixlat_en = 1'b1;
    int          fixlat = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            exp_q.delete();
            next_pc = 32'h0;
            refill();
            exp2 = RPC2;
            prev_redir = 1'b0;
            idle = 0;
        end else begin
            if (!if_id_valid)
                chk("nop_when_invalid", if_id_instruction, NOP);
            if (prev_redir)
                chk("flush_valid", {31'b0, if_id_valid}, 32'h0);
            if (hold_chk && imem_req)
                chk("addr_stable", imem_addr, pend_addr);
            if (redirect_valid) begin
                exp_q.delete();
                next_pc = redirect_pc;
                refill();
                idle++;
            end else if (if_id_valid && !stall) begin
                e = exp_q.pop_front();
                chk("id_pc", if_id_pc, e.pc);
                chk("id_instr", if_id_instruction, e.ins);
                refill();
                cons++;
                idle = 0;
            end else begin
                idle++;
            end
            prev_redir = redirect_valid;
            if (valid2) begin
                chk("wrap_pc", pc2, exp2);
                chk("wrap_instr", inst2, exp2 ^ KEY);
                exp2 = exp2 + 32'd4;
            end
            if (idle > 300) begin
                failures++;
                $display("FAIL progress_timeout actual=%0d idle cycles required<=300", idle);
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        end
    end

    task automatic mem_step();
        hold_chk = imem_req && (pend_cnt > 0);
        if (rst || !imem_req) begin
            imem_rvalid = 1'b0;
            pend_cnt = 0;
        end else if (pend_cnt >= lat) begin
            imem_rvalid = 1'b1;
            imem_rdata  = imem_addr ^ KEY;
            pend_cnt = 0;
            lat = fixlat_en ? fixlat : int'($urandom_range(0, 3));
        end else begin
            imem_rvalid = 1'b0;
            if (pend_cnt == 0) pend_addr = imem_addr;
            pend_cnt++;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        mem_step();
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        while (!if_id_valid && n < 60) begin
            cyc();
            n++;
        end
        if (!if_id_valid) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=invalid required=valid", nm);
        end
    endtask

    task automatic wait_req(input int pc_min, input string nm);
        int n = 0;
        while (!(imem_req && pend_cnt >= pc_min) && n < 60) begin
            cyc();
            n++;
        end
        if (n >= 60) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=no_request required=request", nm);
        end
    endtask

    initial begin
        logic [31:0] saved;
        int          c0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        imem_rvalid = 1'b0;
        imem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'b0, if_id_valid}, 32'h0);
        chk("rst_pc", if_id_pc, 32'h0);
        chk("rst_instr", if_id_instruction, NOP);
        chk("rst2_addr", addr2, RPC2);
        rst = 1'b0;

        // streaming at one instruction per cycle
        fixlat_en = 1'b1; fixlat = 0; lat = 0;
        wait_valid("t1");
        chk("t1_first_pc", if_id_pc, 32'h0);
        chk("t1_first_instr", if_id_instruction, KEY);
        c0 = cons;
        repeat (10) cyc();
        chk("t1_throughput", cons - c0, 32'd10);

        // stall while a response lands: parked in skid
        stall = 1'b1;
        saved = if_id_pc;
        cyc();
        cyc();
        chk("t2_req_off", {31'b0, imem_req}, 32'h0);
        chk("t2_pc_held", if_id_pc, saved);
        chk("t2_valid_held", {31'b0, if_id_valid}, 32'h1);
        stall = 1'b0;
        repeat (6) cyc();

        // redirect while a slow response is outstanding
        fixlat = 4;
        wait_req(1, "t3");
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        cyc();
        redirect_valid = 1'b0;
        chk("t3_valid", {31'b0, if_id_valid}, 32'h0);
        chk("t3_instr", if_id_instruction, NOP);
        wait_valid("t3");
        chk("t3_target_pc", if_id_pc, 32'h100);

        // redirect together with stall
        fixlat = 0;
        repeat (3) cyc();
        wait_valid("t4a");
        stall = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        cyc();
        redirect_valid = 1'b0;
        chk("t4_valid", {31'b0, if_id_valid}, 32'h0);
        chk("t4_instr", if_id_instruction, NOP);
        repeat (3) cyc();
        stall = 1'b0;
        wait_valid("t4b");
        chk("t4_target_pc", if_id_pc, 32'h200);

        // randomized traffic
        fixlat_en = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            cyc();
            stall = ($urandom_range(0, 3) == 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 3))
                0: redirect_pc = 32'hFFFFFFF8;
                1: redirect_pc = $urandom;
                default: redirect_pc = $urandom & 32'hFFFFFFFC;
            endcase
        end
        cyc();
        stall = 1'b0;
        redirect_valid = 1'b0;

        // reset while a request is outstanding
        fixlat_en = 1'b1; fixlat = 3;
        wait_req(1, "t6");
        rst = 1'b1;
        hold_chk = 1'b0;
        #1;
        chk("t6_req", {31'b0, imem_req}, 32'h0);
        chk("t6_addr", imem_addr, 32'h0);
        chk("t6_valid", {31'b0, if_id_valid}, 32'h0);
        chk("t6_pc", if_id_pc, 32'h0);
        chk("t6_instr", if_id_instruction, NOP);
        @(posedge clk);
        #1;
        rst = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = 32'hDEADBEEF;
        pend_cnt = 0;
        lat = 3;
        cyc();
        chk("t6_new_req", {31'b0, imem_req}, 32'h1);
        chk("t6_new_addr", imem_addr, 32'h0);
        wait_valid("t6");
        chk("t6_first_pc", if_id_pc, 32'h0);
        chk("t6_first_instr", if_id_instruction, KEY);
        repeat (5) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
